// File: rtl/chirp_capture.sv
// chirp_capture: records boxcar-decimated I/Q over one chirp window into a dual-port buffer.
// Optional peak tracker is built only when CHIRP_CAPTURE_PEAK_EN is defined.
module chirp_capture #(
    parameter int DW      = 18,
    parameter int AW      = 10,
    parameter int DEC_MAX = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 chirp_status,
    input  logic                 sample_stb,
    input  logic signed [DW-1:0] in_i,
    input  logic signed [DW-1:0] in_q,
    input  logic [2:0]           dec_log2,
    input  logic [AW-1:0]        rd_addr,
    output logic [2*DW-1:0]      rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 full,
    output logic [AW:0]          count,
    output logic [DW-1:0]        peak_mag,
    output logic [AW-1:0]        peak_addr
);

    localparam int ACCW = DW + DEC_MAX;
    localparam int NW   = DEC_MAX + 1;
    localparam logic [AW:0] LAST_IDX = {1'b0, {AW{1'b1}}};

    typedef enum logic [1:0] {IDLE, ARMED, RECORD, DONE} state_t;

    state_t                 state;
    logic                   chirp_status_d;
    logic [2:0]             dec_q;
    logic signed [ACCW-1:0] acc_i, acc_q;
    logic [NW-1:0]          nacc;
    logic                   wr_pending;
    logic [2*DW-1:0]        wr_word;
    logic [2*DW-1:0]        mem [0:(1<<AW)-1];

    logic                   rise, fall, last_write, accept;
    logic [2:0]             dec_clamped;
    logic [NW-1:0]          target, nacc_next;
    logic signed [ACCW-1:0] sum_i, sum_q;
    logic signed [DW-1:0]   avg_i, avg_q;

    assign rise        = chirp_status & ~chirp_status_d;
    assign fall        = ~chirp_status & chirp_status_d;
    assign dec_clamped = (int'(dec_log2) > DEC_MAX) ? 3'(DEC_MAX) : dec_log2;
    assign target      = NW'(1) << dec_q;
    assign nacc_next   = nacc + NW'(1);
    assign sum_i       = acc_i + ACCW'(in_i);
    assign sum_q       = acc_q + ACCW'(in_q);
    assign avg_i       = DW'(sum_i >>> dec_q);
    assign avg_q       = DW'(sum_q >>> dec_q);
    assign busy        = (state == ARMED) || (state == RECORD);

    // The commit that fills the buffer closes the window, so a strobe in that cycle is dropped.
    assign last_write  = wr_pending && (count == LAST_IDX);
    assign accept      = sample_stb &&
                         (((state == ARMED) && rise) ||
                          ((state == RECORD) && !fall && !last_write));

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            chirp_status_d <= 1'b0;
            dec_q          <= '0;
            acc_i          <= '0;
            acc_q          <= '0;
            nacc           <= '0;
            wr_pending     <= 1'b0;
            wr_word        <= '0;
            count          <= '0;
            done           <= 1'b0;
            full           <= 1'b0;
        end else begin
            chirp_status_d <= chirp_status;
            wr_pending     <= 1'b0;
            if (wr_pending)
                count <= count + (AW+1)'(1);
            // A completed block is staged here and committed to memory on the next edge.
            if (accept) begin
                if (nacc_next == target) begin
                    wr_pending <= 1'b1;
                    wr_word    <= {avg_i, avg_q};
                    acc_i      <= '0;
                    acc_q      <= '0;
                    nacc       <= '0;
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                    nacc  <= nacc_next;
                end
            end
            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        state <= ARMED;
                        dec_q <= dec_clamped;
                        count <= '0;
                        done  <= 1'b0;
                        full  <= 1'b0;
                        acc_i <= '0;
                        acc_q <= '0;
                        nacc  <= '0;
                    end
                end
                ARMED: begin
                    if (rise)
                        state <= RECORD;
                end
                RECORD: begin
                    if (last_write) begin
                        state <= DONE;
                        done  <= 1'b1;
                        full  <= 1'b1;
                    end else if (fall) begin
                        state <= DONE;
                        done  <= 1'b1;
                        full  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_pending)
            mem[count[AW-1:0]] <= wr_word;
        rd_data <= mem[rd_addr];
    end

`ifdef CHIRP_CAPTURE_PEAK_EN
    logic            clear_peak;
    logic [DW-1:0]   mag_i, mag_q, wr_mag;

    // Magnitude saturates so the most negative code still fits in DW-1 bits.
    function automatic logic [DW-1:0] sat_abs(input logic signed [DW-1:0] v);
        logic [DW-1:0] a;
        a = v[DW-1] ? DW'(-v) : v;
        return a[DW-1] ? {1'b0, {(DW-1){1'b1}}} : a;
    endfunction

    assign clear_peak = arm && ((state == IDLE) || (state == DONE));
    assign mag_i      = sat_abs(wr_word[2*DW-1:DW]);
    assign mag_q      = sat_abs(wr_word[DW-1:0]);
    assign wr_mag     = (mag_i > mag_q) ? mag_i : mag_q;

    always_ff @(posedge clk) begin
        if (reset || clear_peak) begin
            peak_mag  <= '0;
            peak_addr <= '0;
        end else if (wr_pending && (wr_mag > peak_mag)) begin
            peak_mag  <= wr_mag;
            peak_addr <= count[AW-1:0];
        end
    end
`else
    assign peak_mag  = '0;
    assign peak_addr = '0;
`endif

endmodule

// File: tb/tb_chirp_capture.sv
// tb_chirp_capture: directed vectors with a queued scoreboard checked by a separate monitor.
// Peak expectations follow CHIRP_CAPTURE_PEAK_EN in the same way as the design.
module tb_chirp_capture;

    localparam int DW      = 18;
    localparam int AW      = 6;
    localparam int DEC_MAX = 7;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 arm = 1'b0;
    logic                 chirp_status = 1'b0;
    logic                 sample_stb = 1'b0;
    logic signed [DW-1:0] in_i = '0;
    logic signed [DW-1:0] in_q = '0;
    logic [2:0]           dec_log2 = '0;
    logic [AW-1:0]        rd_addr = '0;
    logic [2*DW-1:0]      rd_data;
    logic                 busy, done, full;
    logic [AW:0]          count;
    logic [DW-1:0]        peak_mag;
    logic [AW-1:0]        peak_addr;

    chirp_capture #(.DW(DW), .AW(AW), .DEC_MAX(DEC_MAX)) dut (
        .clk(clk), .reset(reset), .arm(arm), .chirp_status(chirp_status),
        .sample_stb(sample_stb), .in_i(in_i), .in_q(in_q), .dec_log2(dec_log2),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .full(full),
        .count(count), .peak_mag(peak_mag), .peak_addr(peak_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        int              sel;
        logic [2*DW-1:0] exp;
    } exp_t;

    exp_t            sb[$];
    exp_t            cur;
    logic [2*DW-1:0] act;
    logic            req = 1'b0;
    logic            req_d = 1'b0;
    int              total = 0;
    int              bad = 0;

`ifdef CHIRP_CAPTURE_PEAK_EN
    localparam int EXP_PEAK_MAG  = 200;
    localparam int EXP_PEAK_ADDR = 3;
`else
    localparam int EXP_PEAK_MAG  = 0;
    localparam int EXP_PEAK_ADDR = 0;
`endif

    always @(posedge clk) req_d <= req;

    // Monitor: every request presents its output one edge later and is popped here.
    always @(negedge clk) begin
        if (req_d) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL scoreboard_underrun: got request want queued entry");
            end else begin
                cur = sb.pop_front();
                act = '0;
                case (cur.sel)
                    0: act = rd_data;
                    1: act[AW:0] = count;
                    2: act[0] = done;
                    3: act[0] = full;
                    4: act[0] = busy;
                    5: act[DW-1:0] = peak_mag;
                    default: act[AW-1:0] = peak_addr;
                endcase
                if (act !== cur.exp) begin
                    bad++;
                    $display("[TB] FAIL %s: got %h want %h", cur.name, act, cur.exp);
                end
            end
        end
    end

    function automatic logic [2*DW-1:0] pk(input int i, input int q);
        logic [DW-1:0] a, b;
        a = DW'(i);
        b = DW'(q);
        return {a, b};
    endfunction

    task automatic applyStimulus(input logic ch, input logic stb, input int i, input int q,
                                 input logic a, input int dec);
        chirp_status = ch;
        sample_stb   = stb;
        in_i         = DW'(i);
        in_q         = DW'(q);
        arm          = a;
        dec_log2     = 3'(dec);
        @(negedge clk);
        arm        = 1'b0;
        sample_stb = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int sel, input int exp_val,
                               input int addr = 0);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = (sel == 0) ? pk(exp_val >>> DW, exp_val) : (2*DW)'(exp_val);
        rd_addr = AW'(addr);
        sb.push_back(e);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic checkWord(input string name, input int addr, input int i, input int q);
        exp_t e;
        e.name = name;
        e.sel  = 0;
        e.exp  = pk(i, q);
        rd_addr = AW'(addr);
        sb.push_back(e);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_count", 1, 0);
        checkOutput("rst_done", 2, 0);
        checkOutput("rst_full", 3, 0);
        checkOutput("rst_busy", 4, 0);
        checkOutput("rst_peak_mag", 5, 0);
        checkOutput("rst_peak_addr", 6, 0);

        // Basic ramp capture, fall-cycle strobe must be dropped
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("t1_busy_armed", 4, 1);
        for (int k = 0; k < 40; k++) applyStimulus(1, 1, k, -k, 0, 0);
        applyStimulus(0, 1, 999, 999, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1_count", 1, 40);
        checkOutput("t1_done", 2, 1);
        checkOutput("t1_full", 3, 0);
        checkOutput("t1_busy", 4, 0);
        checkWord("t1_rd5", 5, 5, -5);
        checkWord("t1_rd0", 0, 0, 0);
        checkWord("t1_rd39", 39, 39, -39);

        // Decimate by 4, trailing two samples discarded
        applyStimulus(0, 0, 0, 0, 1, 2);
        for (int k = 0; k < 18; k++) applyStimulus(1, 1, 100, -3, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t2_count", 1, 4);
        checkWord("t2_rd0", 0, 100, -3);
        checkWord("t2_rd3", 3, 100, -3);
        checkWord("t2_rd4_stale", 4, 4, -4);

        // Decimate by 2 with gaps: -7>>>1 rounds toward -inf
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(1, 1, 3, -3, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 4, -4, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, -5, 6, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("trunc_count", 1, 1);
        checkWord("trunc_rd0", 0, 3, -4);

        // Arm while chirp already high, rise/fall strobe rules, arm during RECORD
        applyStimulus(1, 1, 77, 77, 0, 0);
        applyStimulus(1, 1, 77, 77, 1, 0);
        for (int k = 0; k < 3; k++) applyStimulus(1, 1, 77, 77, 0, 0);
        checkOutput("t4_busy_waiting", 4, 1);
        checkOutput("t4_count_waiting", 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 11, -11, 0, 0);
        applyStimulus(1, 1, 12, -12, 0, 0);
        applyStimulus(1, 1, 13, -13, 1, 0);
        applyStimulus(0, 1, 99, 99, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t4_count", 1, 3);
        checkOutput("t4_done", 2, 1);
        checkWord("t4_rd0_rise", 0, 11, -11);
        checkWord("t4_rd2", 2, 13, -13);
        checkWord("t4_rd3_fall_dropped", 3, 100, -3);

        // Buffer exhaustion with chirp still high
        applyStimulus(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 80; k++) applyStimulus(1, 1, k, -k, 0, 0);
        checkOutput("t3_count", 1, 64);
        checkOutput("t3_full", 3, 1);
        checkOutput("t3_done", 2, 1);
        checkOutput("t3_busy", 4, 0);
        checkWord("t3_rd63", 63, 63, -63);
        checkWord("t3_rd0_no_wrap", 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t3_count_hold", 1, 64);

        // Reset in the middle of a recording
        applyStimulus(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 7; k++) applyStimulus(1, 1, 20 + k, k, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        reset = 1'b1;
        applyStimulus(1, 1, 50, 50, 0, 0);
        reset = 1'b0;
        checkOutput("t5_busy", 4, 0);
        checkOutput("t5_done", 2, 0);
        checkOutput("t5_count", 1, 0);
        checkWord("t5_rd6_kept", 6, 26, 6);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, -1, 7, 0, 0);
        applyStimulus(1, 1, -2, 7, 0, 0);
        applyStimulus(1, 1, -3, 7, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t5_recount", 1, 3);
        checkWord("t5_rd0", 0, -1, 7);
        checkWord("t5_rd1", 1, -2, 7);
        checkWord("t5_rd3_stale", 3, 23, 3);

        // Peak tracker, first maximum wins on a tie
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("t6_peak_cleared", 5, 0);
        for (int k = 0; k < 12; k++) begin
            if (k == 3)      applyStimulus(1, 1, -200, 50, 0, 0);
            else if (k == 9) applyStimulus(1, 1, 200, 10, 0, 0);
            else             applyStimulus(1, 1, k, -k, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t6_count", 1, 12);
        checkWord("t6_rd3", 3, -200, 50);
        checkWord("t6_rd9", 9, 200, 10);
        checkOutput("t6_peak_mag", 5, EXP_PEAK_MAG);
        checkOutput("t6_peak_addr", 6, EXP_PEAK_ADDR);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chirp_capture.md
Name: chirp_capture

Overview:
Receive-side companion to the chirp driver. It records the DUT/cavity I/Q response over one chirp window into an on-chip buffer. Recording is gated by the driver's chirp_status and paced by a sample strobe. Input samples are boxcar-decimated by 2^dec_log2 before storage, and host/DSP logic reads the buffer back through a registered random-access read port.

Parameters:
DW, 18, width of signed I/Q input samples
AW, 10, buffer address width (depth 2^AW words)
DEC_MAX, 7, maximum allowed dec_log2 value

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
arm  input  1  single-cycle pulse; arms a capture
chirp_status  input  1  high while chirp active (from chirp driver)
sample_stb  input  1  input sample valid strobe
in_i  input  DW signed  in-phase sample
in_q  input  DW signed  quadrature sample
dec_log2  input  3  decimation exponent, sampled at arm
rd_addr  input  AW  buffer read address
rd_data  output  2*DW  {I,Q} stored word, 1-cycle latency
busy  output  1  high in ARMED or RECORD
done  output  1  capture complete, buffer valid
full  output  1  capture ended by buffer exhaustion
count  output  AW+1  number of words written
peak_mag  output  DW  optional peak tracker (see Optional Feature)
peak_addr  output  AW  optional peak location

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; busy, done, full = 0; count=0; accumulators 0; peak_mag, peak_addr = 0. rd_data is undefined until the first read after reset. Buffer contents are not cleared.
- Edge detect: chirp_status_d is chirp_status registered. Rise = chirp_status & ~chirp_status_d. Fall = ~chirp_status & chirp_status_d.
- FSM states:
  - IDLE: arm -> ARMED. On the same edge, latch dec_q = min(dec_log2, DEC_MAX) and clear count, full, done, peak.
  - ARMED: rise -> RECORD. A chirp already running when armed is not captured; the block waits for the next rise.
  - RECORD: ends on fall (-> DONE, full=0) or on the write that makes count = 2^AW (-> DONE, full=1). If both occur in the same cycle, that write completes and full=1.
  - DONE: done=1 and held. arm -> ARMED, clearing done, full, count and peak.
- arm while ARMED or RECORD is ignored.
- A sample_stb in the rise cycle is the first accumulated sample. A sample_stb in the fall cycle is discarded.
- Accumulation:
  - acc_i and acc_q are DW+DEC_MAX bits signed; nacc is a DEC_MAX+1 bit counter.
  - Each sample_stb in RECORD adds the sample to the accumulators and increments nacc.
  - When nacc reaches 2^dec_q, the block writes {acc_i>>>dec_q, acc_q>>>dec_q} (arithmetic shift, truncation toward -inf) at address count[AW-1:0]. It then increments count and reloads the accumulators with zero.
  - The write occurs on the edge after the completing strobe, so stored latency is 1 cycle.
  - dec_q=0 stores raw samples.
  - A partial accumulation at fall is discarded and never written.
- Read port: rd_data = mem[rd_addr] registered; valid one cycle after rd_addr. Reads are allowed in any state. Unwritten locations return stale data.
- Reset mid-RECORD: the FSM returns to IDLE next edge. Already-written words remain in memory, but count reads 0.
- Memory is a simple dual-port RAM (one write port, one read port), inferable as block RAM.

Optional Feature:
CHIRP_CAPTURE_PEAK_EN
- Defined:
  - On each buffer write, compute mag = max(|I_w|,|Q_w|), saturated to DW-1 magnitude bits, zero-extended to DW.
  - If mag > peak_mag (strict), update peak_mag=mag and peak_addr=write address. The first maximum wins on ties.
  - peak_mag and peak_addr are valid when done=1 and cleared on arm/reset.
- Undefined: peak_mag and peak_addr are tied to 0 and no comparator logic is built.

Test Plan:
1. Basic capture: dec_log2=0, arm, chirp_status high for 40 strobes carrying ramp I=k, Q=-k -> done=1, full=0, count=40, rd_addr=5 yields {5,-5} one cycle later.
2. Decimation and partial discard: dec_log2=2, constant I=100, Q=-3, 18 strobes in window -> count=4, every word {100,-3}; the last 2 samples are not written.
3. Buffer full: AW=4, dec_log2=0, chirp_status held high for 30 strobes -> count=16, full=1, done=1, state leaves RECORD on the 16th write; later strobes do not change memory.
4. Arming and edge rules:
   - arm while chirp_status already high -> no capture until the next rise.
   - Strobe coincident with the rise is stored at address 0.
   - Strobe coincident with the fall is not stored.
   - arm during RECORD does not change count.
5. Reset mid-record: reset asserted after 7 writes -> next cycle busy=0, done=0, count=0. A following arm plus chirp captures normally from address 0.
6. With CHIRP_CAPTURE_PEAK_EN: stored words include {-200,50} at addr 3 and {200,10} at addr 9 -> peak_mag=200, peak_addr=3. Without the macro, both outputs read 0.
